// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port (i_*) and the load/store port (d_*). Load/store requests win, but at
// most MAX_D_RUN back-to-back d grants are given while a fetch is waiting.
// Each transaction runs arbitrate -> memory (held until mem_ready) -> done,
// and the completion strobe and read data go back to the granted port only.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_ena/i_addr        fetch request (held until i_valid)
//   i_valid/i_data      one-cycle fetch completion and fetched word
//   d_r_ena/d_w_ena     load / store request (held until d_valid)
//   d_ext/d_width       sign-extend flag and access width, forwarded to memory
//   d_addr/d_data_in    load/store address and store data
//   d_valid/d_data_out  one-cycle load/store completion and load result
//   mem_*               request side of the backing memory
//
// Optional: define ARB_PERF_EN to add perf_i_grants, perf_d_grants and
// perf_conflicts (32-bit wrapping event counters).
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_r_ena,
  input  logic              d_w_ena,
  input  logic              d_ext,
  input  logic [1:0]        d_width,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_ext,
  output logic [1:0]        mem_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam int unsigned      RUN_W      = 4;
  localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(15);
  localparam logic [RUN_W-1:0] RUN_LIM    = RUN_W'(MAX_D_RUN);
  localparam logic [1:0]       WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_nxt;
  logic [RUN_W-1:0]  d_run_q, d_run_nxt;
  logic              d_pend;
  logic              mem_req_nxt, mem_we_nxt, mem_ext_nxt;
  logic [1:0]        mem_width_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              i_valid_nxt, d_valid_nxt;
  logic [DATA_W-1:0] i_data_nxt, d_data_out_nxt;

  // A store wins if both d enables are raised together.
  assign d_pend = d_r_ena | d_w_ena;

  // Next-state, arbitration and next values of all registered outputs.
  always_comb begin
    state_nxt      = state_q;
    d_run_nxt      = d_run_q;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_ext_nxt    = mem_ext;
    mem_width_nxt  = mem_width;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    i_valid_nxt    = 1'b0;
    d_valid_nxt    = 1'b0;
    i_data_nxt     = i_data;
    d_data_out_nxt = d_data_out;

    unique case (state_q)
      IDLE: begin
        if (d_pend && (!i_ena || (d_run_q < RUN_LIM))) begin
          state_nxt     = GNT_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_w_ena;
          mem_ext_nxt   = d_ext;
          mem_width_nxt = d_width;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_w_ena ? d_data_in : '0;
          // The run length only matters while a fetch is actually waiting.
          if (!i_ena) begin
            d_run_nxt = '0;
          end else if (d_run_q != RUN_SAT) begin
            d_run_nxt = d_run_q + RUN_W'(1);
          end
        end else if (i_ena) begin
          state_nxt     = GNT_I;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_ext_nxt   = 1'b0;
          mem_width_nxt = WIDTH_WORD;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = '0;
          d_run_nxt     = '0;
        end else begin
          d_run_nxt = '0;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          i_valid_nxt = 1'b1;
          i_data_nxt  = mem_rdata;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          state_nxt      = DONE;
          mem_req_nxt    = 1'b0;
          d_valid_nxt    = 1'b1;
          d_data_out_nxt = mem_we ? '0 : mem_rdata;
        end
      end
      // Strobe cycle: requests still held by the requester are not re-issued.
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      d_run_q    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_ext    <= 1'b0;
      mem_width  <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_data     <= '0;
      d_data_out <= '0;
    end else begin
      state_q    <= state_nxt;
      d_run_q    <= d_run_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_ext    <= mem_ext_nxt;
      mem_width  <= mem_width_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      i_valid    <= i_valid_nxt;
      d_valid    <= d_valid_nxt;
      i_data     <= i_data_nxt;
      d_data_out <= d_data_out_nxt;
    end
  end

`ifdef ARB_PERF_EN
  logic grant_i, grant_d, conflict;

  assign grant_i  = (state_q == IDLE) && (state_nxt == GNT_I);
  assign grant_d  = (state_q == IDLE) && (state_nxt == GNT_D);
  assign conflict = (state_q == IDLE) && i_ena && d_pend;

  // Wrapping event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_i)  perf_i_grants  <= perf_i_grants + 32'd1;
      if (grant_d)  perf_d_grants  <= perf_d_grants + 32'd1;
      if (conflict) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst) !(i_valid && d_valid));
  a_one_d_req:  assert property (@(posedge clk) disable iff (!rst) !(d_r_ena && d_w_ena));
`endif

endmodule
